// File: rtl/mem_byte_seq.sv
// Byte-level command sequencer ahead of the mem_ctrl serdes: frames each burst with cs_n and sends opcode, address, data.
// Optional build macro MEM_SEQ_FAST_READ_EN: fast-read opcode 8'h0B plus one dummy byte before read data.
module mem_byte_seq #(
    parameter int          ADDR_W    = 24,
    parameter int          LEN_W     = 8,
    parameter logic [7:0]  OPC_READ  = 8'h03,
    parameter logic [7:0]  OPC_WRITE = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        ser_data,
    output logic              ser_start,
    input  logic              ser_done,
    output logic              des_start,
    input  logic [7:0]        des_data,
    input  logic              des_done,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);
    localparam int AB    = ADDR_W / 8;
    localparam int CNT_W = (AB > 1) ? $clog2(AB) : 1;

`ifdef MEM_SEQ_FAST_READ_EN
    localparam logic [7:0] RD_OPC = 8'h0B;
`else
    localparam logic [7:0] RD_OPC = OPC_READ;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_RHOLD, S_FINISH
`ifdef MEM_SEQ_FAST_READ_EN
        , S_DUMMY
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inflight_q, inflight_d;
    logic               blank_q, blank_d;
    logic [7:0]         ser_data_q, ser_data_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               xfer_done;
    logic               complete;
    logic [7:0]         ser_byte;

    // blank_q marks the cycle after a start pulse; done is ignored then and in the start cycle itself
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        blank_d    = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        ser_start  = 1'b0;
        des_start  = 1'b0;
        wr_ready   = 1'b0;
        ser_byte   = 8'h00;
        xfer_done  = (state_q == S_RDATA) ? des_done : ser_done;
        complete   = inflight_q && !blank_q && xfer_done;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    rem_d   = {1'b0, req_len} + (LEN_W+1)'(1);
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                ser_byte = write_q ? OPC_WRITE : RD_OPC;
                if (!inflight_q) begin
                    ser_start  = 1'b1;
                    inflight_d = 1'b1;
                    blank_d    = 1'b1;
                end else if (complete) begin
                    inflight_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                ser_byte = addr_q[ADDR_W-1 -: 8];
                if (!inflight_q) begin
                    ser_start  = 1'b1;
                    inflight_d = 1'b1;
                    blank_d    = 1'b1;
                end else if (complete) begin
                    inflight_d = 1'b0;
                    addr_d     = addr_q << 8;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(AB - 1)) begin
`ifdef MEM_SEQ_FAST_READ_EN
                        state_d = write_q ? S_WDATA : S_DUMMY;
`else
                        state_d = write_q ? S_WDATA : S_RDATA;
`endif
                    end
                end
            end
`ifdef MEM_SEQ_FAST_READ_EN
            S_DUMMY: begin
                ser_byte = 8'h00;
                if (!inflight_q) begin
                    ser_start  = 1'b1;
                    inflight_d = 1'b1;
                    blank_d    = 1'b1;
                end else if (complete) begin
                    inflight_d = 1'b0;
                    state_d    = S_RDATA;
                end
            end
`endif
            S_WDATA: begin
                ser_byte = wr_data;
                wr_ready = !inflight_q;
                if (!inflight_q) begin
                    if (wr_valid) begin
                        ser_start  = 1'b1;
                        inflight_d = 1'b1;
                        blank_d    = 1'b1;
                    end
                end else if (complete) begin
                    inflight_d = 1'b0;
                    rem_d      = rem_q - (LEN_W+1)'(1);
                    if (rem_q == (LEN_W+1)'(1)) state_d = S_FINISH;
                end
            end
            S_RDATA: begin
                if (!inflight_q) begin
                    des_start  = 1'b1;
                    inflight_d = 1'b1;
                    blank_d    = 1'b1;
                end else if (complete) begin
                    inflight_d = 1'b0;
                    rd_data_d  = des_data;
                    rd_valid_d = 1'b1;
                    rem_d      = rem_q - (LEN_W+1)'(1);
                    state_d    = S_RHOLD;
                end
            end
            S_RHOLD: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = (rem_q != '0) ? S_RDATA : S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // ser_data shows the new byte in its start cycle and then holds it for the serialiser
        ser_data   = ser_start ? ser_byte : ser_data_q;
        ser_data_d = ser_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            blank_q    <= 1'b0;
            ser_data_q <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            blank_q    <= blank_d;
            ser_data_q <= ser_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign cs_n      = (state_q == S_IDLE) || (state_q == S_FINISH);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed bench for mem_byte_seq with behavioural serdes, write-source and read-sink models.
// Expectations for read bursts follow MEM_SEQ_FAST_READ_EN when it is defined.
module tb_mem_byte_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready = 1'b0;
    logic [7:0]  ser_data;
    logic        ser_start, ser_done = 1'b0;
    logic        des_start;
    logic [7:0]  des_data = '0;
    logic        des_done = 1'b0;
    logic        cs_n, busy, done;

    mem_byte_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .ser_data(ser_data), .ser_start(ser_start), .ser_done(ser_done),
        .des_start(des_start), .des_data(des_data), .des_done(des_done),
        .cs_n(cs_n), .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model state and observation logs
    logic [7:0] ser_log[$], rd_log[$], wr_src[$], des_src[$], exp_q[$];
    logic [7:0] des_cur = '0, hold_data = '0;
    logic       wr_hs = 1'b0, prev_cs_n = 1'b1, rd_hold_prev = 1'b0;
    int ser_lat = 3, des_lat = 3, wr_gap = 0, gap_cnt = 0, ser_cnt = 0, des_cnt = 0;
    int ser_starts = 0, done_cnt = 0, wr_acc = 0;
    int cs_viol = 0, gap_viol = 0, hold_viol = 0, stab_viol = 0, start_cs_viol = 0;
    int n_chk = 0, n_pass = 0;

    // monitor: samples DUT outputs mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            ser_cnt = 0;
            des_cnt = 0;
            wr_hs = 1'b0;
            rd_hold_prev = 1'b0;
            prev_cs_n = 1'b1;
        end else begin
            wr_hs = wr_valid && wr_ready;
            if (wr_hs) wr_acc++;
            if (ser_start) begin
                ser_log.push_back(ser_data);
                ser_starts++;
                ser_cnt = ser_lat;
                if (cs_n) start_cs_viol++;
                if (wr_ready && !wr_valid) gap_viol++;
            end
            if (des_start) begin
                des_cur = (des_src.size() > 0) ? des_src.pop_front() : 8'hEE;
                des_cnt = des_lat;
                if (rd_valid) hold_viol++;
            end
            if (rd_hold_prev && (!rd_valid || rd_data !== hold_data)) stab_viol++;
            rd_hold_prev = rd_valid && !rd_ready;
            hold_data = rd_data;
            if (rd_valid && rd_ready) rd_log.push_back(rd_data);
            if (done) begin
                done_cnt++;
                if (!cs_n || prev_cs_n) cs_viol++;
            end
            if (busy && !done && cs_n) cs_viol++;
            prev_cs_n = cs_n;
        end
    end

    // serdes and write-source drivers: update just after the active edge
    always @(posedge clk) begin
        #1;
        ser_done = 1'b0;
        if (ser_cnt > 0) begin
            ser_cnt--;
            if (ser_cnt == 0) ser_done = 1'b1;
        end
        des_done = 1'b0;
        if (des_cnt > 0) begin
            des_cnt--;
            if (des_cnt == 0) begin
                des_done = 1'b1;
                des_data = des_cur;
            end
        end
        if (wr_hs) begin
            wr_hs = 1'b0;
            void'(wr_src.pop_front());
            wr_valid = 1'b0;
            gap_cnt = wr_gap;
        end
        if (!wr_valid && wr_src.size() > 0) begin
            if (gap_cnt > 0) gap_cnt--;
            else begin
                wr_valid = 1'b1;
                wr_data = wr_src[0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        logic [7:0] g;
        chk({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            chk($sformatf("%s[%0d]", tag, i), {24'h0, g}, {24'h0, exp[i]});
        end
    endtask

    task automatic do_req(input logic w, input logic [23:0] a, input logic [7:0] l);
        req_write = w;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) step();
        chk(tag, done_cnt - base, 1);
    endtask

    task automatic wait_rd(input string tag, input int budget);
        for (int i = 0; i < budget && !rd_valid; i++) step();
        chk(tag, rd_valid, 1'b1);
    endtask

    // directed stimulus
    initial begin
        int b_acc, b_done, b_start, b_hold;
        logic [7:0] v;

        repeat (3) step();
        chk("reset_outputs",
            {req_ready, cs_n, busy, done, wr_ready, rd_valid, ser_start, des_start, ser_data, rd_data},
            24'hC00000);
        rst = 1'b0;
        step();

        // write, two bytes
        ser_log.delete();
        wr_src = '{8'hA5, 8'h5A};
        b_acc = wr_acc;
        do_req(1'b1, 24'h123456, 8'd1);
        wait_done("wr1_done", 200);
        exp_q = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hA5, 8'h5A};
        chk_q("wr1_ser", ser_log, exp_q);
        chk("wr1_acc", wr_acc - b_acc, 2);
        chk("wr1_idle", {busy, req_ready, cs_n}, 3'b011);
        step();
        chk("wr1_one_done", done_cnt, 1);

        // read, one byte, consumer initially stalled
        ser_log.delete();
        rd_log.delete();
        des_src = '{8'h3C};
        do_req(1'b0, 24'h000010, 8'd0);
        wait_rd("rd1_valid", 200);
        chk("rd1_data", rd_data, 8'h3C);
        b_done = done_cnt;
        repeat (3) step();
        chk("rd1_no_early_done", done_cnt - b_done, 0);
        rd_ready = 1'b1;
        wait_done("rd1_done", 20);
        rd_ready = 1'b0;
`ifdef MEM_SEQ_FAST_READ_EN
        exp_q = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'h00};
`else
        exp_q = '{8'h03, 8'h00, 8'h00, 8'h10};
`endif
        chk_q("rd1_ser", ser_log, exp_q);
        exp_q = '{8'h3C};
        chk_q("rd1_rd", rd_log, exp_q);

        // read, three bytes, second byte held for 10 cycles
        ser_log.delete();
        rd_log.delete();
        des_src = '{8'h11, 8'h22, 8'h33};
        rd_ready = 1'b1;
        do_req(1'b0, 24'hABCDEF, 8'd2);
        for (int i = 0; i < 200 && rd_log.size() < 1; i++) step();
        chk("rd2_first", rd_log.size(), 1);
        rd_ready = 1'b0;
        wait_rd("rd2_valid2", 100);
        b_hold = hold_viol;
        repeat (10) step();
        chk("rd2_hold_data", rd_data, 8'h22);
        chk("rd2_hold_valid", rd_valid, 1'b1);
        chk("rd2_no_des_start", hold_viol - b_hold, 0);
        rd_ready = 1'b1;
        wait_done("rd2_done", 100);
        rd_ready = 1'b0;
        chk("rd2_stable", stab_viol, 0);
        exp_q = '{8'h11, 8'h22, 8'h33};
        chk_q("rd2_rd", rd_log, exp_q);
`ifdef MEM_SEQ_FAST_READ_EN
        exp_q = '{8'h0B, 8'hAB, 8'hCD, 8'hEF, 8'h00};
`else
        exp_q = '{8'h03, 8'hAB, 8'hCD, 8'hEF};
`endif
        chk_q("rd2_ser", ser_log, exp_q);

        // write with 5-cycle gaps; a second request is offered while busy
        ser_log.delete();
        wr_gap = 5;
        gap_cnt = 0;
        wr_src = '{8'hC1, 8'hC2, 8'hC3};
        b_acc = wr_acc;
        do_req(1'b1, 24'h000001, 8'd2);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            chk("busy_req_ready", req_ready, 1'b0);
            step();
        end
        req_valid = 1'b0;
        wait_done("wr2_done", 300);
        exp_q = '{8'h02, 8'h00, 8'h00, 8'h01, 8'hC1, 8'hC2, 8'hC3};
        chk_q("wr2_ser", ser_log, exp_q);
        chk("wr2_gap_start", gap_viol, 0);
        chk("wr2_acc", wr_acc - b_acc, 3);
        wr_gap = 0;
        gap_cnt = 0;

        // reset while the second address byte is in flight
        ser_log.delete();
        des_src = '{8'h99};
        b_start = ser_starts;
        do_req(1'b0, 24'h445566, 8'd0);
        for (int i = 0; i < 100 && ser_starts - b_start < 3; i++) step();
        chk("rst_at_addr2", ser_starts - b_start, 3);
        rst = 1'b1;
        step();
        chk("rst_state", {cs_n, busy, req_ready, done, ser_start, des_start, rd_valid, wr_ready}, 8'b10100000);
        rst = 1'b0;
        des_src.delete();
        b_done = done_cnt;
        repeat (8) step();
        chk("rst_no_done", done_cnt - b_done, 0);
        chk("rst_cs_high", cs_n, 1'b1);
        ser_log.delete();
        wr_src = '{8'h77};
        do_req(1'b1, 24'h0000FF, 8'd0);
        wait_done("rst_new_done", 200);
        exp_q = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h77};
        chk_q("rst_new_ser", ser_log, exp_q);

        // maximum burst: 256 bytes, one spare byte must stay unaccepted
        ser_log.delete();
        ser_lat = 2;
        for (int i = 0; i < 257; i++) begin
            v = 8'(i) ^ 8'h5A;
            wr_src.push_back(v);
        end
        b_acc = wr_acc;
        do_req(1'b1, 24'h00ABCD, 8'hFF);
        wait_done("max_done", 3000);
        repeat (5) step();
        chk("max_acc", wr_acc - b_acc, 256);
        chk("max_left", wr_src.size(), 1);
        chk("max_ser_len", ser_log.size(), 260);
        chk("max_addr_lsb", (ser_log.size() > 3) ? ser_log[3] : 8'hxx, 8'hCD);
        chk("max_first", (ser_log.size() > 4) ? ser_log[4] : 8'hxx, 8'h5A);
        chk("max_last", (ser_log.size() > 259) ? ser_log[259] : 8'hxx, 8'hA5);
        wr_src.delete();
        wr_valid = 1'b0;

        chk("cs_framing", cs_viol, 0);
        chk("start_cs_high", start_cs_viol, 0);
        chk("done_total", done_cnt, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
